// File: rtl/usb_rx.sv
// USB full-speed receive path: line synchronisation, bit recovery, NRZI decode and unstuffing,
// SYNC/PID/EOP framing, and payload streaming into the packet buffer with the CRC16 withheld.
module usb_rx #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       dplus_in,
    input  logic       dminus_in,
    input  logic [6:0] buffer_occupancy,
    output logic [7:0] rx_packet_data,
    output logic       store_rx_packet_data,
    output logic       flush,
    output logic [3:0] rx_packet,
    output logic       rx_data_ready,
    output logic       rx_transfer_active,
    output logic       rx_error
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
    // More consecutive J samples than bit stuffing allows inside a packet.
    localparam logic [3:0] IdleArm = 4'd8;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StPid,
        StPayload,
        StEop,
        StErrWait
    } state_e;

    state_e          state_q;
    logic            dp_meta_q, dp_sync_q, dm_meta_q, dm_sync_q, dp_prev_q;
    logic [CntW-1:0] phase_q;
    logic            level_q;
    logic [2:0]      ones_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic [1:0]      byte_cnt_q;
    logic [7:0]      hold1_q, hold0_q;
    logic            is_data_q;
    logic            se0_seen_q;
    logic [3:0]      idle_run_q;

    logic       edge_det, strobe;
    logic       line_se0, line_j, line_k;
    logic       nrzi_bit;
    logic [7:0] new_byte;
    logic       pid_ok, hold_full, bit_state, boundary_ok;
    logic       err_now;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_meta_q <= 1'b1;
            dp_sync_q <= 1'b1;
            dm_meta_q <= 1'b0;
            dm_sync_q <= 1'b0;
            dp_prev_q <= 1'b1;
            phase_q   <= '0;
        end else begin
            dp_meta_q <= dplus_in;
            dp_sync_q <= dp_meta_q;
            dm_meta_q <= dminus_in;
            dm_sync_q <= dm_meta_q;
            dp_prev_q <= dp_sync_q;
            if (edge_det || phase_q == LastCnt) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_q + CntW'(1);
            end
        end
    end

    assign edge_det  = dp_sync_q ^ dp_prev_q;
    // A strobe coinciding with a resync edge would sample the new bit twice.
    assign strobe    = (phase_q == HalfM1) && !edge_det;
    assign line_se0  = !dp_sync_q && !dm_sync_q;
    assign line_j    = dp_sync_q && !dm_sync_q;
    assign line_k    = !dp_sync_q && dm_sync_q;
    assign nrzi_bit  = (dp_sync_q == level_q);
    assign new_byte  = {nrzi_bit, shift_q[7:1]};
    assign pid_ok    = (new_byte[7:4] == ~new_byte[3:0]);
    assign hold_full = (byte_cnt_q == 2'd2);
    assign bit_state = (state_q == StSync) || (state_q == StPid) || (state_q == StPayload);
    assign boundary_ok = (state_q == StPayload) && (bit_cnt_q == 3'd0) &&
                         !(is_data_q && !hold_full);

    always_comb begin
        err_now = 1'b0;
        if (strobe) begin
            if (bit_state) begin
                if (line_se0) begin
                    err_now = !boundary_ok;
                end else if (ones_q == 3'd6) begin
                    err_now = nrzi_bit;
                end else if (bit_cnt_q == 3'd7) begin
                    case (state_q)
                        StSync:  err_now = (new_byte != 8'h80);
                        StPid:   err_now = !pid_ok;
                        default: err_now = is_data_q && hold_full &&
                                           (buffer_occupancy >= 7'd64);
                    endcase
                end
            end else if (state_q == StEop) begin
                err_now = line_k || (line_j && !se0_seen_q);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q              <= StIdle;
            level_q              <= 1'b1;
            ones_q               <= '0;
            bit_cnt_q            <= '0;
            shift_q              <= '0;
            byte_cnt_q           <= '0;
            hold1_q              <= '0;
            hold0_q              <= '0;
            is_data_q            <= 1'b0;
            se0_seen_q           <= 1'b0;
            idle_run_q           <= '0;
            rx_packet_data       <= '0;
            store_rx_packet_data <= 1'b0;
            flush                <= 1'b0;
            rx_packet            <= '0;
            rx_data_ready        <= 1'b0;
            rx_transfer_active   <= 1'b0;
            rx_error             <= 1'b0;
        end else begin
            store_rx_packet_data <= 1'b0;
            flush                <= 1'b0;
            rx_data_ready        <= 1'b0;
            if (strobe) begin
                level_q <= dp_sync_q;
                if (err_now) begin
                    state_q            <= StErrWait;
                    rx_error           <= 1'b1;
                    rx_transfer_active <= 1'b0;
                    se0_seen_q         <= line_se0;
                end else begin
                    unique case (state_q)
                        StIdle: begin
                            ones_q <= '0;
                            if (line_j) begin
                                if (idle_run_q != IdleArm) begin
                                    idle_run_q <= idle_run_q + 4'd1;
                                end
                            end else if (line_k && idle_run_q == IdleArm) begin
                                state_q   <= StSync;
                                shift_q   <= new_byte;
                                bit_cnt_q <= 3'd1;
                            end else if (idle_run_q != IdleArm) begin
                                idle_run_q <= '0;
                            end
                        end
                        StSync, StPid, StPayload: begin
                            if (line_se0) begin
                                state_q    <= StEop;
                                se0_seen_q <= 1'b1;
                            end else if (ones_q == 3'd6) begin
                                ones_q <= '0;
                            end else begin
                                ones_q    <= nrzi_bit ? ones_q + 3'd1 : 3'd0;
                                shift_q   <= new_byte;
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                if (bit_cnt_q == 3'd7) begin
                                    if (state_q == StSync) begin
                                        state_q            <= StPid;
                                        rx_transfer_active <= 1'b1;
                                        rx_error           <= 1'b0;
                                    end else if (state_q == StPid) begin
                                        rx_packet  <= new_byte[3:0];
                                        is_data_q  <= (new_byte[2:0] == 3'b011);
                                        byte_cnt_q <= '0;
                                        if (new_byte[3:0] == 4'b0010 ||
                                            new_byte[3:0] == 4'b1010 ||
                                            new_byte[3:0] == 4'b1110) begin
                                            state_q    <= StEop;
                                            se0_seen_q <= 1'b0;
                                        end else begin
                                            state_q <= StPayload;
                                            flush   <= (new_byte[2:0] == 3'b011);
                                        end
                                    end else begin
                                        // Two-byte holdback keeps the CRC16 out of the buffer.
                                        if (is_data_q && hold_full) begin
                                            rx_packet_data       <= hold1_q;
                                            store_rx_packet_data <= 1'b1;
                                        end
                                        hold1_q <= hold0_q;
                                        hold0_q <= new_byte;
                                        if (!hold_full) begin
                                            byte_cnt_q <= byte_cnt_q + 2'd1;
                                        end
                                    end
                                end
                            end
                        end
                        StEop: begin
                            if (line_se0) begin
                                se0_seen_q <= 1'b1;
                            end else if (line_j) begin
                                rx_data_ready      <= is_data_q;
                                rx_transfer_active <= 1'b0;
                                state_q            <= StIdle;
                                idle_run_q         <= IdleArm;
                            end
                        end
                        StErrWait: begin
                            if (line_se0) begin
                                se0_seen_q <= 1'b1;
                            end else if (line_j && se0_seen_q) begin
                                state_q    <= StIdle;
                                idle_run_q <= IdleArm;
                            end
                        end
                        default: state_q <= StIdle;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_rx.sv
// Self-checking bench for usb_rx: NRZI/stuffing line encoder, store scoreboard, scenario tasks.
module tb_usb_rx;

    localparam int unsigned CLKS_PER_BIT = 8;
    localparam int IDLE_BITS = 12;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       dplus_in;
    logic       dminus_in;
    logic [6:0] buffer_occupancy;
    logic [7:0] rx_packet_data;
    logic       store_rx_packet_data;
    logic       flush;
    logic [3:0] rx_packet;
    logic       rx_data_ready;
    logic       rx_transfer_active;
    logic       rx_error;

    int checks = 0;
    int failures = 0;
    int store_cnt = 0;
    int flush_cnt = 0;
    int ready_cnt = 0;
    logic store_prev = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];

    usb_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) dut (
        .clk                 (clk),
        .n_rst               (n_rst),
        .dplus_in            (dplus_in),
        .dminus_in           (dminus_in),
        .buffer_occupancy    (buffer_occupancy),
        .rx_packet_data      (rx_packet_data),
        .store_rx_packet_data(store_rx_packet_data),
        .flush               (flush),
        .rx_packet           (rx_packet),
        .rx_data_ready       (rx_data_ready),
        .rx_transfer_active  (rx_transfer_active),
        .rx_error            (rx_error)
    );

    always #5 clk = ~clk;

    // Scoreboard: every store strobe pops the oldest expected payload byte.
    always @(negedge clk) begin
        logic [7:0] want;
        if (store_rx_packet_data) begin
            store_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL store_unexpected got=%02h want=none", rx_packet_data);
            end else begin
                want = exp_q.pop_front();
                if (rx_packet_data !== want) begin
                    failures++;
                    $display("FAIL store_data got=%02h want=%02h", rx_packet_data, want);
                end
            end
            checks++;
            if (store_prev !== 1'b0) begin
                failures++;
                $display("FAIL store_width got=back_to_back want=single_cycle");
            end
        end
        if (flush) flush_cnt++;
        if (rx_data_ready) ready_cnt++;
        store_prev = store_rx_packet_data;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic send_sym(input logic dp, input logic dm);
        dplus_in  = dp;
        dminus_in = dm;
        repeat (CLKS_PER_BIT) @(negedge clk);
    endtask

    // SYNC + tx_q bytes, LSB first, stuffed and NRZI-encoded, then EOP and idle.
    task automatic send_packet(input bit bad_stuff);
        bit         bits[$];
        logic [7:0] b;
        int         ones;
        bit         lvl;
        bit         injected;
        ones = 0;
        injected = 0;
        tx_q.push_front(8'h80);
        foreach (tx_q[k]) begin
            b = tx_q[k];
            for (int i = 0; i < 8; i++) begin
                bits.push_back(b[i]);
                ones = b[i] ? ones + 1 : 0;
                if (ones == 6) begin
                    bits.push_back(bad_stuff && !injected);
                    injected = 1;
                    ones = 0;
                end
            end
        end
        tx_q.delete();
        lvl = 1;
        foreach (bits[i]) begin
            if (!bits[i]) lvl = !lvl;
            send_sym(lvl, !lvl);
        end
        send_sym(1'b0, 1'b0);
        send_sym(1'b0, 1'b0);
        repeat (IDLE_BITS) send_sym(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        checks++;
        if (rx_packet !== 4'b0000) begin
            failures++;
            $display("FAIL reset_rx_packet got=%b want=0000", rx_packet);
        end
        checks++;
        if ({store_rx_packet_data, flush, rx_data_ready} !== 3'b000) begin
            failures++;
            $display("FAIL reset_strobes got=%b want=000",
                     {store_rx_packet_data, flush, rx_data_ready});
        end
        checks++;
        if ({rx_transfer_active, rx_error} !== 2'b00 || rx_packet_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_status got=%b/%02h want=00/00",
                     {rx_transfer_active, rx_error}, rx_packet_data);
        end
    endtask

    task automatic test_ack();
        int s0, f0, r0;
        s0 = store_cnt;
        f0 = flush_cnt;
        r0 = ready_cnt;
        tx_q = {8'hD2};
        fork
            send_packet(1'b0);
            begin
                repeat (4 * CLKS_PER_BIT) @(negedge clk);
                checks++;
                if (rx_transfer_active !== 1'b0) begin
                    failures++;
                    $display("FAIL ack_active_in_sync got=%b want=0", rx_transfer_active);
                end
                repeat (8 * CLKS_PER_BIT) @(negedge clk);
                checks++;
                if (rx_transfer_active !== 1'b1) begin
                    failures++;
                    $display("FAIL ack_active_in_pid got=%b want=1", rx_transfer_active);
                end
                checks++;
                if (rx_error !== 1'b0) begin
                    failures++;
                    $display("FAIL ack_error_cleared_at_sync got=%b want=0", rx_error);
                end
            end
        join
        checks++;
        if (rx_packet !== 4'b0010) begin
            failures++;
            $display("FAIL ack_pid got=%b want=0010", rx_packet);
        end
        checks++;
        if (rx_transfer_active !== 1'b0 || rx_error !== 1'b0) begin
            failures++;
            $display("FAIL ack_end_status got=%b%b want=00", rx_transfer_active, rx_error);
        end
        checks++;
        if (store_cnt - s0 != 0 || flush_cnt - f0 != 0 || ready_cnt - r0 != 0) begin
            failures++;
            $display("FAIL ack_no_pulses got=%0d/%0d/%0d want=0/0/0",
                     store_cnt - s0, flush_cnt - f0, ready_cnt - r0);
        end
    endtask

    task automatic test_data(input logic [7:0] pid, input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] c0, input logic [7:0] c1, input bit bad_stuff);
        int s0, f0, r0;
        s0 = store_cnt;
        f0 = flush_cnt;
        r0 = ready_cnt;
        tx_q = {pid, p0, p1, c0, c1};
        if (!bad_stuff) begin
            exp_q.push_back(p0);
            exp_q.push_back(p1);
        end
        send_packet(bad_stuff);
        checks++;
        if (rx_packet !== pid[3:0]) begin
            failures++;
            $display("FAIL data_pid got=%b want=%b", rx_packet, pid[3:0]);
        end
        checks++;
        if (flush_cnt - f0 != 1) begin
            failures++;
            $display("FAIL data_flush got=%0d want=1", flush_cnt - f0);
        end
        checks++;
        if (store_cnt - s0 != (bad_stuff ? 0 : 2)) begin
            failures++;
            $display("FAIL data_store_count got=%0d want=%0d", store_cnt - s0,
                     bad_stuff ? 0 : 2);
        end
        checks++;
        if (ready_cnt - r0 != (bad_stuff ? 0 : 1)) begin
            failures++;
            $display("FAIL data_ready got=%0d want=%0d", ready_cnt - r0, bad_stuff ? 0 : 1);
        end
        checks++;
        if (rx_error !== bad_stuff) begin
            failures++;
            $display("FAIL data_error got=%b want=%b", rx_error, bad_stuff);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL data_missing_stores got=%0d_left want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_pid_fail(input logic [3:0] prev_pid);
        int s0;
        s0 = store_cnt;
        tx_q = {8'h33};
        send_packet(1'b0);
        checks++;
        if (rx_error !== 1'b1) begin
            failures++;
            $display("FAIL pidfail_error got=%b want=1", rx_error);
        end
        checks++;
        if (rx_packet !== prev_pid) begin
            failures++;
            $display("FAIL pidfail_pid_held got=%b want=%b", rx_packet, prev_pid);
        end
        checks++;
        if (store_cnt != s0 || rx_transfer_active !== 1'b0) begin
            failures++;
            $display("FAIL pidfail_quiet got=%0d/%b want=0/0", store_cnt - s0,
                     rx_transfer_active);
        end
    endtask

    task automatic test_overflow();
        int s0, f0, r0;
        s0 = store_cnt;
        f0 = flush_cnt;
        r0 = ready_cnt;
        buffer_occupancy = 7'd64;
        tx_q = {8'hC3, 8'h10, 8'h20, 8'h30, 8'h40, 8'h55, 8'h66};
        send_packet(1'b0);
        buffer_occupancy = 7'd0;
        checks++;
        if (rx_error !== 1'b1) begin
            failures++;
            $display("FAIL overflow_error got=%b want=1", rx_error);
        end
        checks++;
        if (store_cnt - s0 != 0 || ready_cnt - r0 != 0) begin
            failures++;
            $display("FAIL overflow_no_store got=%0d/%0d want=0/0", store_cnt - s0,
                     ready_cnt - r0);
        end
        checks++;
        if (flush_cnt - f0 != 1) begin
            failures++;
            $display("FAIL overflow_flush got=%0d want=1", flush_cnt - f0);
        end
    endtask

    task automatic test_reset_mid_packet();
        int f0;
        f0 = flush_cnt;
        tx_q = {8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        fork
            send_packet(1'b0);
            begin
                repeat (30 * CLKS_PER_BIT) @(negedge clk);
                checks++;
                if (rx_transfer_active !== 1'b1) begin
                    failures++;
                    $display("FAIL midrst_active_before got=%b want=1", rx_transfer_active);
                end
                n_rst = 1'b0;
                #1;
                checks++;
                if ({store_rx_packet_data, flush, rx_data_ready, rx_transfer_active, rx_error}
                    !== 5'b00000 || rx_packet !== 4'b0000 || rx_packet_data !== 8'h00) begin
                    failures++;
                    $display("FAIL midrst_outputs got=%b/%b/%02h want=00000/0000/00",
                             {store_rx_packet_data, flush, rx_data_ready, rx_transfer_active,
                              rx_error}, rx_packet, rx_packet_data);
                end
                n_rst = 1'b1;
            end
        join
        checks++;
        if (rx_error !== 1'b0 || rx_transfer_active !== 1'b0) begin
            failures++;
            $display("FAIL midrst_tail_ignored got=%b%b want=00", rx_error, rx_transfer_active);
        end
        test_data(8'hC3, 8'h5A, 8'hA5, 8'h12, 8'h34, 1'b0);
        checks++;
        if (flush_cnt - f0 != 2) begin
            failures++;
            $display("FAIL midrst_flush_total got=%0d want=2", flush_cnt - f0);
        end
    endtask

    initial begin
        n_rst = 1'b0;
        dplus_in = 1'b1;
        dminus_in = 1'b0;
        buffer_occupancy = 7'd0;
        repeat (3) @(negedge clk);
        test_reset();
        n_rst = 1'b1;
        repeat (IDLE_BITS) send_sym(1'b1, 1'b0);
        test_ack();
        test_data(8'hC3, 8'h01, 8'h02, 8'hAA, 8'hBB, 1'b0);
        test_data(8'h4B, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0);
        test_data(8'h4B, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1);
        test_pid_fail(4'b1011);
        test_ack();
        test_overflow();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_rx.md
# usb_rx

USB full-speed receive path: the counterpart of the transmit path, sitting between the D+/D− pins and the receive side of the shared 64-byte packet buffer. It recovers bit timing from the line, NRZI-decodes, removes stuffed bits, detects SYNC and EOP, and validates the PID. It streams DATA-packet payload bytes into the buffer, withholding the two CRC16 bytes. It reports the packet type and error status to the protocol controller.

## Interface
- CLKS_PER_BIT, 8, system clocks per USB bit (even, ≥ 4)
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- dplus_in  in  1  raw D+ line (asynchronous)
- dminus_in  in  1  raw D− line (asynchronous)
- buffer_occupancy  in  7  current buffer byte count, 0..64
- rx_packet_data  out  8  byte to write into the buffer
- store_rx_packet_data  out  1  one-cycle write strobe for rx_packet_data
- flush  out  1  one-cycle pulse: clear the buffer before a new DATA packet
- rx_packet  out  4  PID[3:0] of the last accepted packet
- rx_data_ready  out  1  one-cycle pulse: DATA packet received cleanly
- rx_transfer_active  out  1  high from SYNC complete to EOP or abort
- rx_error  out  1  packet error flag

## Operation
- Input stage: 2-flop synchronizer on each line. SE0 = both synchronized lines low. J = D+ high and D− low; K = D+ low and D− high.
- Bit timing: the phase counter clears on any synchronized D+ edge. A sample strobe fires when the count reaches CLKS_PER_BIT/2 − 1, then every CLKS_PER_BIT cycles.
- NRZI: bit = 1 if the sampled level equals the previous sample, else 0. The previous-level register resets to J (1).
- Unstuff: a ones counter (0..6) increments on each 1 and clears on each 0.
  - After 6 ones, the next bit is discarded if it is 0.
  - If that bit is 1, it is a stuff error.
- Shifter: LSB-first 8-bit shift of unstuffed bits. It raises byte_done for one cycle after the 8th bit.
- FSM states: IDLE, SYNC, PID, PAYLOAD, EOP, ERR_WAIT.
  - IDLE → SYNC on the first K.
  - SYNC: the first byte must be 0x80 (KJKJKJKK). On pass → PID and rx_transfer_active=1. On fail → ERR_WAIT.
  - PID: accept the byte if PID[7:4] == ~PID[3:0], then latch rx_packet = PID[3:0].
    - Handshake PIDs (ACK 0010, NAK 1010, STALL 1110) → EOP.
    - DATA0 (0011) or DATA1 (1011) → pulse flush, then → PAYLOAD.
    - Token PIDs → PAYLOAD with stores suppressed; the two token bytes are discarded.
    - Check fail → ERR_WAIT.
  - PAYLOAD: a 2-byte holdback pipeline (hold1, hold0).
    - On each byte_done with both holds full, store hold1: rx_packet_data = hold1, store_rx_packet_data = 1. Then shift the new byte in.
    - SE0 at a byte boundary → EOP.
  - EOP: requires SE0 for ≥ 1 sample, then J. Held bytes are discarded as CRC.
    - For a DATA PID with ≥ 2 bytes received, pulse rx_data_ready.
    - rx_transfer_active then falls → IDLE.
  - ERR_WAIT: assert rx_error and discard all bits. On SE0 followed by J → IDLE, with rx_transfer_active=0.
- Errors, each entering ERR_WAIT: bad SYNC, PID check fail, stuff error, SE0 mid-byte, DATA packet with fewer than 2 bytes after the PID, and a store required while buffer_occupancy == 64.
- rx_error stays set until the next SYNC passes, and clears in that cycle. rx_packet holds its value until the next PID is accepted.
- No CRC check is done in this block.

## Timing
- Reset values: all outputs 0, rx_packet = 4'b0000, FSM = IDLE, ones counter = 0.
- A line edge reaches the edge detector 2 cycles after the pin change.
- byte_done occurs 1 cycle after the sample strobe of the byte's 8th unstuffed bit. store_rx_packet_data and flush assert in that same cycle, for exactly 1 cycle.
- rx_data_ready asserts 1 cycle after the first J sample following SE0.
- Stores happen at most once per 8 bit times, so no back-to-back strobes are possible.
- Simultaneous events:
  - Overflow and SE0 in the same byte_done cycle: overflow wins and rx_error is set.
  - SYNC pass in the same cycle rx_error clears: rx_error reads 0.
- Reset mid-packet: immediate return to IDLE with all outputs 0. The rest of the packet is ignored until the line idles (J) and a new SYNC arrives.

## Test plan
- ACK packet (SYNC, PID 0xD2, EOP) → rx_packet=0010, rx_transfer_active high SYNC→EOP, no store/flush/ready/error.
- DATA0 (0xC3) with payload 0x01 0x02 and CRC 0xAA 0xBB → flush once; stores of 0x01 then 0x02 only; rx_data_ready once; rx_error=0.
- DATA1 with payload 0xFF 0xFF and CRC 0x00 0x00, driven with correct stuffed zeros → stores of 0xFF 0xFF; no error. The same stream with the stuffed bit driven as a 1 → rx_error, no rx_data_ready.
- PID 0x33 (check fail) → rx_error=1, rx_packet unchanged, no stores. A following valid ACK → rx_error clears at SYNC, rx_packet=0010.
- DATA0 with 4 payload bytes, buffer_occupancy held at 64 → rx_error on the first required store, no strobe, no rx_data_ready.
- n_rst pulsed mid-payload → all outputs 0 immediately. A following clean DATA0 packet is received correctly.
